ili9341_rx: RTL and testbench

- Responder end of the 8-bit 8080-style LCD write bus that ili9341-class drivers emit (lcd_data, lcd_we_n, lcd_rs, lcd_fmark).
- Decodes command and parameter bytes, tracks the CASET/PASET window and the RAMWR pointer, and assembles RGB565 pixels.
- Emits one framebuffer write per pixel and generates the tearing-effect pulse (lcd_fmark).
- Used as a synthesizable display model in the quartz-gpu benches, and as the front end when driving a non-ILI panel from the same driver.

---
 rtl/ili9341_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_ili9341_rx.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_rx.sv
// ili9341_rx: responder for an 8080-style 8-bit LCD write bus.
// Decodes commands and parameters, tracks the CASET/PASET window and
// the RAMWR pointer, emits one framebuffer write per RGB565 pixel, and
// generates the tearing-effect pulse.
// Ports: clk, rst (sync, high); lcd_data/lcd_we_n/lcd_rs bus in;
// lcd_fmark TE out; fb_we/fb_addr/fb_data pixel write; disp_on, awake.
module ili9341_rx #(
  parameter int WIDTH         = 240,
  parameter int HEIGHT        = 320,
  parameter int FRAME_CYCLES  = 100000,
  parameter int VBLANK_CYCLES = 1000,
  parameter int ADDR_W        = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        lcd_data,
  input  logic              lcd_we_n,
  input  logic              lcd_rs,
  output logic              lcd_fmark,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_data,
  output logic              disp_on,
  output logic              awake
);

  localparam logic [15:0] EC_DEF = 16'(WIDTH - 1);
  localparam logic [15:0] EP_DEF = 16'(HEIGHT - 1);
  localparam logic [15:0] W16    = 16'(WIDTH);
  localparam logic [15:0] H16    = 16'(HEIGHT);
  localparam int CW =
    (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES - 1);

  localparam logic [7:0] C_SWRST   = 8'h01;
  localparam logic [7:0] C_SLPIN   = 8'h10;
  localparam logic [7:0] C_SLPOUT  = 8'h11;
  localparam logic [7:0] C_DISPOFF = 8'h28;
  localparam logic [7:0] C_DISPON  = 8'h29;
  localparam logic [7:0] C_CASET   = 8'h2A;
  localparam logic [7:0] C_PASET   = 8'h2B;
  localparam logic [7:0] C_RAMWR   = 8'h2C;
  localparam logic [7:0] C_TEOFF   = 8'h34;
  localparam logic [7:0] C_TEON    = 8'h35;
  localparam logic [7:0] C_RAMWRC  = 8'h3C;

  localparam logic [1:0] K_CASET = 2'd0;
  localparam logic [1:0] K_PASET = 2'd1;
  localparam logic [1:0] K_TEON  = 2'd2;

  typedef enum logic [1:0] {
    S_CMD,
    S_PARAM,
    S_PIXEL,
    S_SKIP
  } state_t;

  state_t r_state, w_state_nx;

  logic        r_we1, r_we2, r_we3;
  logic [7:0]  r_d1, r_d2;
  logic        r_rs1, r_rs2;

  logic [15:0] r_sc, r_ec, r_sp, r_ep;
  logic [15:0] r_col, r_page;
  logic        r_te_en, r_disp, r_awake;
  logic        r_have_hi;
  logic [7:0]  r_hi;
  logic [1:0]  r_pcnt, r_pkind;
  logic [7:0]  r_p0, r_p1, r_p2;
  logic        r_fb_we;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [15:0] r_fb_data;
  logic [CW-1:0] r_cnt;

  logic        w_acc, w_cmd, w_dat, w_srst;
  logic        w_plast, w_inr;
  logic [15:0] w_ec, w_ep;
  logic [ADDR_W-1:0] w_addr;

  // Data and rs ride the same two stages as the strobe, so the
  // byte in r_d2 is the one present when lcd_we_n rose.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we1 <= 1'b1;
      r_we2 <= 1'b1;
      r_we3 <= 1'b1;
      r_d1  <= 8'h00;
      r_d2  <= 8'h00;
      r_rs1 <= 1'b0;
      r_rs2 <= 1'b0;
    end else begin
      r_we1 <= lcd_we_n;
      r_we2 <= r_we1;
      r_we3 <= r_we2;
      r_d1  <= lcd_data;
      r_d2  <= r_d1;
      r_rs1 <= lcd_rs;
      r_rs2 <= r_rs1;
    end
  end

  assign w_acc  = r_we2 & ~r_we3;
  assign w_cmd  = w_acc & ~r_rs2;
  assign w_dat  = w_acc & r_rs2;
  assign w_srst = w_cmd && (r_d2 == C_SWRST);

  assign w_plast = (r_pkind == K_TEON) || (r_pcnt == 2'd3);

  // An inverted window collapses to its start column/page.
  assign w_ec   = (r_sc > r_ec) ? r_sc : r_ec;
  assign w_ep   = (r_sp > r_ep) ? r_sp : r_ep;
  assign w_inr  = (r_col < W16) && (r_page < H16);
  assign w_addr = ADDR_W'(r_page) * ADDR_W'(WIDTH)
                + ADDR_W'(r_col);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CMD;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_cmd) begin
      case (r_d2)
        C_CASET, C_PASET, C_TEON: w_state_nx = S_PARAM;
        C_RAMWR, C_RAMWRC:        w_state_nx = S_PIXEL;
        C_TEOFF, C_SLPIN, C_SLPOUT,
        C_DISPON, C_DISPOFF,
        C_SWRST:                  w_state_nx = S_CMD;
        default:                  w_state_nx = S_SKIP;
      endcase
    end else if (w_dat && r_state == S_PARAM && w_plast) begin
      w_state_nx = S_CMD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_srst) begin
      r_sc      <= 16'h0000;
      r_ec      <= EC_DEF;
      r_sp      <= 16'h0000;
      r_ep      <= EP_DEF;
      r_col     <= 16'h0000;
      r_page    <= 16'h0000;
      r_te_en   <= 1'b0;
      r_disp    <= 1'b0;
      r_awake   <= 1'b0;
      r_have_hi <= 1'b0;
      r_hi      <= 8'h00;
      r_pcnt    <= 2'd0;
      r_pkind   <= K_CASET;
      r_p0      <= 8'h00;
      r_p1      <= 8'h00;
      r_p2      <= 8'h00;
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= 16'h0000;
    end else begin
      r_fb_we <= 1'b0;
      if (w_cmd) begin
        r_have_hi <= 1'b0;
        r_pcnt    <= 2'd0;
        case (r_d2)
          C_CASET:   r_pkind <= K_CASET;
          C_PASET:   r_pkind <= K_PASET;
          C_TEON:    r_pkind <= K_TEON;
          C_RAMWR: begin
            r_col  <= r_sc;
            r_page <= r_sp;
          end
          C_TEOFF:   r_te_en <= 1'b0;
          C_SLPOUT:  r_awake <= 1'b1;
          C_SLPIN:   r_awake <= 1'b0;
          C_DISPON:  r_disp  <= 1'b1;
          C_DISPOFF: r_disp  <= 1'b0;
          default: ;
        endcase
      end else if (w_dat && r_state == S_PARAM) begin
        r_pcnt <= r_pcnt + 2'd1;
        if (r_pkind == K_TEON) begin
          r_te_en <= 1'b1;
        end else if (r_pcnt == 2'd0) begin
          r_p0 <= r_d2;
        end else if (r_pcnt == 2'd1) begin
          r_p1 <= r_d2;
        end else if (r_pcnt == 2'd2) begin
          r_p2 <= r_d2;
        end else if (r_pkind == K_CASET) begin
          r_sc <= {r_p0, r_p1};
          r_ec <= {r_p2, r_d2};
        end else begin
          r_sp <= {r_p0, r_p1};
          r_ep <= {r_p2, r_d2};
        end
      end else if (w_dat && r_state == S_PIXEL) begin
        if (!r_have_hi) begin
          r_hi      <= r_d2;
          r_have_hi <= 1'b1;
        end else begin
          r_have_hi <= 1'b0;
          r_fb_we   <= w_inr;
          r_fb_data <= {r_hi, r_d2};
          r_fb_addr <= w_addr;
          if (r_col == w_ec) begin
            r_col  <= r_sc;
            r_page <= (r_page == w_ep) ? r_sp
                                       : r_page + 16'd1;
          end else begin
            r_col <= r_col + 16'd1;
          end
        end
      end
    end
  end

  // Free-running frame counter; soft reset leaves it alone.
  always_ff @(posedge clk) begin
    if (rst)                  r_cnt <= '0;
    else if (r_cnt == CNT_LAST) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end

  assign lcd_fmark = r_te_en
                   && (32'(r_cnt) < 32'(VBLANK_CYCLES));
  assign fb_we     = r_fb_we;
  assign fb_addr   = r_fb_addr;
  assign fb_data   = r_fb_data;
  assign disp_on   = r_disp;
  assign awake     = r_awake;

endmodule

// File: tb/tb_ili9341_rx.sv
// tb_ili9341_rx: randomized self-checking bench for ili9341_rx.
// Drives the 8080 bus and compares writes/flags/TE against a model.
module tb_ili9341_rx;

  localparam int W  = 240;
  localparam int H  = 320;
  localparam int FR = 200;
  localparam int VB = 20;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    lcd_data;
  logic          lcd_we_n;
  logic          lcd_rs;
  logic          lcd_fmark;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_data;
  logic          disp_on;
  logic          awake;

  ili9341_rx #(
    .WIDTH(W), .HEIGHT(H), .FRAME_CYCLES(FR),
    .VBLANK_CYCLES(VB), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .lcd_data(lcd_data),
    .lcd_we_n(lcd_we_n), .lcd_rs(lcd_rs),
    .lcd_fmark(lcd_fmark), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .disp_on(disp_on), .awake(awake)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  // observed writes
  int unsigned obs_a[$];
  int unsigned obs_d[$];
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      obs_a.push_back(int'(fb_addr));
      obs_d.push_back(int'(fb_data));
      chk("we_width", {31'd0, prev_we}, 32'd0);
    end
    prev_we <= fb_we;
  end

  // frame position model: cycles since rst, modulo FR
  int k = 0;
  always @(posedge clk) begin
    if (rst)          k <= 0;
    else if (k == FR - 1) k <= 0;
    else              k <= k + 1;
  end

  // reference model
  int unsigned exp_a[$];
  int unsigned exp_d[$];
  int   m_sc, m_ec, m_sp, m_ep, m_col, m_page;
  int   m_mode;  // 0 idle, 1 collecting params, 2 pixels, 3 skip
  int   m_pk;    // 0 column, 1 page, 2 te
  bit   m_te, m_disp, m_awake, m_hv;
  logic [7:0] m_hi;
  logic [7:0] m_pq[$];

  function automatic void m_reset();
    m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1;
    m_col = 0; m_page = 0; m_mode = 0; m_pk = 0;
    m_te = 0; m_disp = 0; m_awake = 0; m_hv = 0;
    m_hi = 8'h00;
    m_pq.delete();
  endfunction

  task automatic model(input logic rs, input logic [7:0] d);
    int a, b, last_c, last_p;
    if (!rs) begin
      m_pq.delete();
      m_hv = 0;
      case (d)
        8'h2A: begin m_mode = 1; m_pk = 0; end
        8'h2B: begin m_mode = 1; m_pk = 1; end
        8'h35: begin m_mode = 1; m_pk = 2; end
        8'h2C: begin
          m_col = m_sc; m_page = m_sp; m_mode = 2;
        end
        8'h3C: m_mode = 2;
        8'h34: begin m_te = 0; m_mode = 0; end
        8'h11: begin m_awake = 1; m_mode = 0; end
        8'h10: begin m_awake = 0; m_mode = 0; end
        8'h29: begin m_disp = 1; m_mode = 0; end
        8'h28: begin m_disp = 0; m_mode = 0; end
        8'h01: m_reset();
        default: m_mode = 3;
      endcase
    end else if (m_mode == 1) begin
      m_pq.push_back(d);
      if (m_pk == 2) begin
        m_te = 1; m_mode = 0;
      end else if (m_pq.size() == 4) begin
        a = int'({m_pq[0], m_pq[1]});
        b = int'({m_pq[2], m_pq[3]});
        if (m_pk == 0) begin m_sc = a; m_ec = b; end
        else           begin m_sp = a; m_ep = b; end
        m_pq.delete();
        m_mode = 0;
      end
    end else if (m_mode == 2) begin
      if (!m_hv) begin
        m_hi = d; m_hv = 1;
      end else begin
        m_hv = 0;
        if (m_col < W && m_page < H) begin
          exp_a.push_back(m_page * W + m_col);
          exp_d.push_back(int'({m_hi, d}));
        end
        last_c = (m_sc > m_ec) ? m_sc : m_ec;
        last_p = (m_sp > m_ep) ? m_sp : m_ep;
        if (m_col == last_c) begin
          m_col  = m_sc;
          m_page = (m_page == last_p) ? m_sp : m_page + 1;
        end else begin
          m_col = m_col + 1;
        end
      end
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs   = rs;
    lcd_data = d;
    lcd_we_n = 1'b0;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    lcd_we_n = 1'b1;
    repeat ($urandom_range(4, 6)) @(negedge clk);
    model(rs, d);
  endtask

  task automatic cmd(input logic [7:0] d);
    send(1'b0, d);
  endtask

  task automatic dat(input logic [7:0] d);
    send(1'b1, d);
  endtask

  task automatic pix(input logic [15:0] v);
    dat(v[15:8]);
    dat(v[7:0]);
  endtask

  task automatic win(input logic [7:0] c,
                     input logic [15:0] s,
                     input logic [15:0] e);
    cmd(c);
    dat(s[15:8]); dat(s[7:0]);
    dat(e[15:8]); dat(e[7:0]);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_n"}, obs_a.size(), exp_a.size());
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      chk({tag, "_a"}, obs_a[i], exp_a[i]);
      chk({tag, "_d"}, obs_d[i], exp_d[i]);
    end
    obs_a.delete(); obs_d.delete();
    exp_a.delete(); exp_d.delete();
  endtask

  task automatic last_addr(input string tag, input int unsigned v);
    chk(tag, (obs_a.size() > 0) ? obs_a[$] : 32'hFFFF_FFFF, v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic idle_fmark(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      chk("fmark", {31'd0, lcd_fmark},
          (m_te && k < VB) ? 32'd1 : 32'd0);
      if (lcd_fmark) highs++;
    end
  endtask

  function automatic logic [15:0] rcoord(input int lim);
    return 16'($urandom_range(0, lim + 8));
  endfunction

  int hi_cnt;
  int fill_a[5] = '{1210, 1211, 1450, 1451, 1210};
  int fill_d[5] = '{'hF800, 'h07E0, 'h001F, 'hFFFF, 'h1234};
  logic [7:0] flagc[7] = '{8'h11, 8'h10, 8'h29, 8'h28,
                           8'h34, 8'h01, 8'h00};
  logic [7:0] othc[4] = '{8'h36, 8'h3A, 8'h00, 8'hB1};

  initial begin
    int n, sel;
    logic [15:0] s, e;
    rst      = 1'b1;
    lcd_we_n = 1'b1;
    lcd_rs   = 1'b0;
    lcd_data = 8'h00;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_we", {31'd0, fb_we}, 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_disp", {31'd0, disp_on}, 0);
    chk("rst_awake", {31'd0, awake}, 0);
    chk("rst_fmark", {31'd0, lcd_fmark}, 0);

    idle_fmark(2 * FR, hi_cnt);
    chk("idle_te_hi", hi_cnt, 0);
    drain("idle");

    cmd(8'h35); dat(8'h00);
    idle_fmark(2 * FR, hi_cnt);
    chk("te_hi", hi_cnt, 2 * VB);
    cmd(8'h34);
    idle_fmark(FR, hi_cnt);
    chk("teoff_hi", hi_cnt, 0);

    win(8'h2A, 16'd10, 16'd11);
    win(8'h2B, 16'd5, 16'd6);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) pix(16'(fill_d[i]));
    repeat (4) @(negedge clk);
    chk("fill_n", obs_a.size(), 5);
    for (int i = 0; i < 5 && i < obs_a.size(); i++) begin
      chk("fill_ca", obs_a[i], fill_a[i]);
      chk("fill_cd", obs_d[i], fill_d[i]);
    end
    drain("fill");

    do_reset();
    cmd(8'h2C);
    repeat (240) pix(16'($urandom));
    repeat (4) @(negedge clk);
    last_addr("def_last", 239);
    drain("def");
    cmd(8'h3C);
    pix(16'hA5C3);
    repeat (4) @(negedge clk);
    last_addr("cont_addr", 240);
    drain("cont");

    cmd(8'h2A); dat(8'h00); dat(8'h14);
    cmd(8'h2C);
    pix(16'h5A5A);
    repeat (4) @(negedge clk);
    chk("abort_n", obs_a.size(), 1);
    last_addr("abort_addr", 0);
    drain("abort");

    cmd(8'h2C);
    dat(8'h11); dat(8'h22); dat(8'h33);
    cmd(8'h00);
    cmd(8'h3C);
    dat(8'h44); dat(8'h55);
    repeat (4) @(negedge clk);
    chk("odd_n", obs_a.size(), 2);
    last_addr("odd_addr", 1);
    chk("odd_data", (obs_d.size() > 0) ? obs_d[$] : 0, 'h4455);
    drain("odd");

    win(8'h2A, 16'h00EF, 16'h0100);
    cmd(8'h2C);
    pix(16'h0F0F); pix(16'hF0F0);
    repeat (4) @(negedge clk);
    chk("oor_n", obs_a.size(), 1);
    last_addr("oor_addr", 239);
    drain("oor");

    cmd(8'h11); cmd(8'h29);
    chk("awake_on", {31'd0, awake}, 1);
    chk("disp_on", {31'd0, disp_on}, 1);
    cmd(8'h01);
    chk("awake_sw", {31'd0, awake}, 0);
    chk("disp_sw", {31'd0, disp_on}, 0);
    chk("addr_sw", 32'(fb_addr), 0);
    cmd(8'h2C);
    pix(16'h1357); pix(16'h2468);
    drain("swrst");

    cmd(8'h2C);
    dat(8'hAB);
    do_reset();
    dat(8'hCD);
    drain("rstpix");
    cmd(8'h2C);
    pix(16'hBEEF);
    drain("rstpix2");

    repeat (25) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: begin
          s = rcoord(W);
          e = ($urandom_range(0, 3) == 0) ? rcoord(W)
                                          : s + 16'($urandom_range(0, 5));
          win(8'h2A, s, e);
        end
        1: begin
          s = rcoord(H);
          e = ($urandom_range(0, 3) == 0) ? rcoord(H)
                                          : s + 16'($urandom_range(0, 5));
          win(8'h2B, s, e);
        end
        2: begin
          cmd($urandom_range(0, 1) ? 8'h2A : 8'h2B);
          repeat ($urandom_range(0, 3)) dat(8'($urandom));
        end
        3, 4: begin
          cmd($urandom_range(0, 1) ? 8'h2C : 8'h3C);
          n = $urandom_range(1, 30);
          repeat (n) pix(16'($urandom));
          if ($urandom_range(0, 2) == 0) dat(8'($urandom));
        end
        5: cmd(flagc[$urandom_range(0, 6)]);
        6: begin
          cmd(othc[$urandom_range(0, 3)]);
          repeat ($urandom_range(0, 4)) dat(8'($urandom));
        end
        default: begin
          if ($urandom_range(0, 1)) begin
            cmd(8'h35); dat(8'($urandom));
          end
          repeat ($urandom_range(1, 3)) dat(8'($urandom));
        end
      endcase
      drain("rnd");
    end
    chk("rnd_awake", {31'd0, awake}, {31'd0, m_awake});
    chk("rnd_disp", {31'd0, disp_on}, {31'd0, m_disp});
    idle_fmark(FR, hi_cnt);
    chk("rnd_te_hi", hi_cnt, m_te ? VB : 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
